// File: rtl/entrada_moedas.sv
// entrada_moedas: synchronised, debounced coin-sensor front end with reject pulse and post-coin lockout
module entrada_moedas #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LOCKOUT_CYCLES  = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       inhibit,
  output logic [1:0] moeda,
  output logic       rejeitar,
  output logic       busy
);
  localparam int MAXC = DEBOUNCE_CYCLES > LOCKOUT_CYCLES ? DEBOUNCE_CYCLES : LOCKOUT_CYCLES;
  localparam int W = $clog2(MAXC + 1);
  localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [W-1:0] LK_LAST = W'(LOCKOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE, LOCKOUT} state_t;
  state_t         state_q, state_d;
  logic [1:0]     sync1_q, sync2_q, pat_q, pat_d, moeda_q, moeda_d;
  logic           rej_q, rej_d;
  logic [W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [1:0]     p;
  assign p        = sync2_q;
  assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + W'(1);
  assign moeda    = moeda_q;
  assign rejeitar = rej_q;
  assign busy     = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    moeda_d = 2'b00;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (p != 2'b00) begin
          state_d = DEBOUNCE;
          pat_d   = p;
        end
      end
      DEBOUNCE: begin
        if (p == 2'b00) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (p != pat_q) begin
          // coin rolling between sensors: the last stable pattern wins
          pat_d = p;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
          moeda_d = inhibit ? 2'b00 : pat_q;
          rej_d   = inhibit;
        end else cnt_d = cnt_inc;
      end
      WAIT_RELEASE: begin
        if (p != 2'b00) cnt_d = '0;
        else if (cnt_q == DB_LAST) begin
          state_d = LOCKOUT;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
      default: begin
        if (cnt_q == LK_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_inc;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      state_q <= IDLE;
      pat_q   <= 2'b00;
      cnt_q   <= '0;
      moeda_q <= 2'b00;
      rej_q   <= 1'b0;
    end else begin
      sync1_q <= {sensor_b, sensor_a};
      sync2_q <= sync1_q;
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      moeda_q <= moeda_d;
      rej_q   <= rej_d;
    end
  end
endmodule

// File: tb/tb_entrada_moedas.sv
// tb_entrada_moedas: table-driven coin scenarios, hand corner cases and a randomized run against a timestamp model
module tb_entrada_moedas;
  localparam int D = 4;
  localparam int L = 8;
  logic       clk, reset, sensor_a, sensor_b, inhibit;
  logic [1:0] moeda;
  logic       rejeitar, busy;
  int n_assert = 0;
  int n_fail   = 0;

  entrada_moedas #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .inhibit(inhibit), .moeda(moeda), .rejeitar(rejeitar), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, int'(busy), 0);
    repeat (3) tick();
  endtask

  // per-scenario statistics, offsets counted in edges from E0
  int         st_first, st_pulses, st_both, st_rise, st_fall, st_m01;
  logic [1:0] st_m;
  logic       st_r;

  task automatic coin(input logic [1:0] p0, input int h0, input logic [1:0] p1, input int h1,
                      input logic inh, input int edges);
    st_first = -1; st_pulses = 0; st_both = 0; st_rise = -1; st_fall = -1; st_m01 = 0;
    st_m = 2'b00; st_r = 1'b0;
    inhibit = inh;
    {sensor_b, sensor_a} = h0 > 0 ? p0 : p1;
    for (int k = 0; k < edges; k++) begin
      tick();
      {sensor_b, sensor_a} = (k + 1 < h0) ? p0 : (k + 1 < h0 + h1) ? p1 : 2'b00;
      if (moeda != 2'b00 || rejeitar) begin
        if (st_first < 0) begin
          st_first = k;
          st_m = moeda;
          st_r = rejeitar;
        end
        st_pulses++;
      end
      if (moeda != 2'b00 && rejeitar) st_both++;
      if (moeda == 2'b01) st_m01++;
      if (busy && st_rise < 0) st_rise = k;
      if (!busy && st_rise >= 0 && st_fall < 0) st_fall = k;
    end
    inhibit = 1'b0;
  endtask

  typedef struct {
    logic [1:0] pat;
    int         hold;
    logic       inh;
    logic [1:0] em;
    logic       er;
    int         at;
    int         fall;
  } vec_t;
  vec_t vt[7];

  // Reference model: decides each edge's outputs from run-length timestamps of the
  // synchronised pattern (p at edge n is the sensor sample taken at edge n-2).
  logic [1:0] hist[$];
  logic [1:0] m_last_p, e_moeda;
  logic       e_rej, e_busy;
  int         m_n, m_chg, m_mode, m_avail, m_emit, m_rel;

  task automatic model_init();
    hist.delete();
    m_n = 0; m_chg = 0; m_mode = 0; m_avail = 0; m_emit = 0; m_rel = 0;
    m_last_p = 2'b00; e_moeda = 2'b00; e_rej = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] s, input logic inh);
    logic [1:0] p;
    int         rs;
    p = (m_n >= 2) ? hist[m_n - 2] : 2'b00;
    hist.push_back(s);
    if (p != m_last_p) begin
      m_last_p = p;
      m_chg = m_n;
    end
    e_moeda = 2'b00;
    e_rej = 1'b0;
    if (m_mode == 0) begin
      rs = m_chg > m_avail ? m_chg : m_avail;
      e_busy = p != 2'b00;
      if (p != 2'b00 && m_n - rs == D) begin
        m_mode = 1;
        m_emit = m_n;
        e_rej = inh;
        e_moeda = inh ? 2'b00 : p;
      end
    end else if (m_mode == 1) begin
      rs = m_chg > m_emit + 1 ? m_chg : m_emit + 1;
      e_busy = 1'b1;
      if (p == 2'b00 && m_n - rs == D - 1) begin
        m_mode = 2;
        m_rel = m_n;
      end
    end else begin
      e_busy = 1'b1;
      if (m_n == m_rel + L) begin
        m_mode = 0;
        m_avail = m_n + 1;
        e_busy = 1'b0;
      end
    end
    m_n++;
  endtask

  initial begin
    int         seg, bad;
    logic [1:0] cur_s;
    logic       cur_inh;
    vt[0] = '{2'b01, 10, 1'b0, 2'b01, 1'b0,  6, 23};
    vt[1] = '{2'b10,  3, 1'b0, 2'b00, 1'b0, -1,  5};
    vt[2] = '{2'b10, 10, 1'b1, 2'b00, 1'b1,  6, 23};
    vt[3] = '{2'b11,  6, 1'b0, 2'b11, 1'b0,  6, 19};
    vt[4] = '{2'b01,  4, 1'b0, 2'b00, 1'b0, -1,  6};
    vt[5] = '{2'b01,  5, 1'b0, 2'b01, 1'b0,  6, 18};
    vt[6] = '{2'b10, 12, 1'b0, 2'b10, 1'b0,  6, 25};
    reset = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0; inhibit = 1'b0;
    #1;
    chk("reset_moeda", int'(moeda), 0);
    chk("reset_rej", int'(rejeitar), 0);
    chk("reset_busy", int'(busy), 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) begin
      coin(vt[i].pat, vt[i].hold, 2'b00, 0, vt[i].inh, 40);
      chk($sformatf("vec%0d_at", i), st_first, vt[i].at);
      chk($sformatf("vec%0d_moeda", i), int'(st_m), int'(vt[i].em));
      chk($sformatf("vec%0d_rej", i), int'(st_r), int'(vt[i].er));
      chk($sformatf("vec%0d_pulses", i), st_pulses, vt[i].at < 0 ? 0 : 1);
      chk($sformatf("vec%0d_both", i), st_both, 0);
      chk($sformatf("vec%0d_rise", i), st_rise, 2);
      chk($sformatf("vec%0d_fall", i), st_fall, vt[i].fall);
      wait_idle($sformatf("vec%0d", i));
    end

    coin(2'b01, 2, 2'b11, 10, 1'b0, 40);
    chk("roll_at", st_first, 8);
    chk("roll_moeda", int'(st_m), 3);
    chk("roll_pulses", st_pulses, 1);
    chk("roll_no01", st_m01, 0);
    chk("roll_fall", st_fall, 25);
    wait_idle("roll");

    coin(2'b01, 10, 2'b00, 0, 1'b0, 18);
    chk("lock_first_at", st_first, 6);
    chk("lock_first_01", st_m01, 1);
    coin(2'b01, 3, 2'b00, 0, 1'b0, 10);
    chk("lock_ignored", st_pulses, 0);
    chk("lock_fall", st_fall, 5);
    wait_idle("lock");
    coin(2'b01, 10, 2'b00, 0, 1'b0, 40);
    chk("lock_third_at", st_first, 6);
    chk("lock_third_01", st_m01, 1);
    wait_idle("third");

    sensor_a = 1'b1;
    repeat (5) tick();
    chk("rst_pre_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    sensor_a = 1'b0;
    #1;
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_moeda", int'(moeda), 0);
    chk("rst_async_rej", int'(rejeitar), 0);
    tick();
    tick();
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy || rejeitar || moeda != 2'b00) bad++;
    end
    chk("rst_no_pulse", bad, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_init();
    cur_s = 2'b00;
    cur_inh = 1'b0;
    seg = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      model_edge(cur_s, cur_inh);
      chk("rand_moeda", int'(moeda), int'(e_moeda));
      chk("rand_rej", int'(rejeitar), int'(e_rej));
      chk("rand_busy", int'(busy), int'(e_busy));
      if (seg == 0) begin
        seg = $urandom_range(1, 14);
        cur_s = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      end
      seg--;
      cur_inh = $urandom_range(0, 3) == 0;
      {sensor_b, sensor_a} = cur_s;
      inhibit = cur_inh;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/entrada_moedas.md
# entrada_moedas

Coin-acceptor front end that conditions the two raw coin-sensor lines and produces the 2-bit `moeda` code consumed by the vending-machine top level and its accumulator. It synchronises and debounces the sensors and classifies the coin. It emits each accepted coin as a single-cycle code, or fires a reject pulse when the machine is inhibited. It then locks out further input until the coin has cleared the chute.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a sensor pattern; also the required release time (≥2)
- LOCKOUT_CYCLES, 250000, dead time after release during which sensors are ignored (≥1)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears every register including synchronisers
- sensor_a  input  1  raw asynchronous sensor, small coin
- sensor_b  input  1  raw asynchronous sensor, large coin
- inhibit  input  1  synchronous; 1 = machine not accepting coins (dispensing/returning)
- moeda  output  2  coin code, non-zero for exactly one cycle per accepted coin; 00 otherwise
- rejeitar  output  1  one-cycle pulse driving the return gate
- busy  output  1  1 whenever FSM is not in IDLE

## Operation
- Two-flop synchroniser per sensor; FSM sees only synchronised pattern p = {sensor_b_s, sensor_a_s}.
- Coin code from captured pattern: 01 = a only, 10 = b only, 11 = both.
- Counter width = clog2(max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES)+1); saturating, never wraps.
- States:
  - IDLE: count=0. p≠00 → capture p into pat, go DEBOUNCE.
  - DEBOUNCE:
    - p==pat → count+1.
    - p≠pat and p≠00 → recapture pat=p, count=0 (coin rolling from one sensor to the other; final stable pattern wins).
    - p==00 → IDLE, no output (glitch).
    - count reaches DEBOUNCE_CYCLES-1 with p==pat → emit, go WAIT_RELEASE.
  - Emit:
    - inhibit=0 → moeda=pat for one cycle.
    - inhibit=1 → rejeitar=1 for one cycle, moeda stays 00.
    - inhibit is sampled in the emit cycle only.
  - WAIT_RELEASE: p==00 → count+1, else count=0. Count reaches DEBOUNCE_CYCLES-1 → LOCKOUT, count=0. Pattern changes here never produce a second emission.
  - LOCKOUT: sensors ignored; count reaches LOCKOUT_CYCLES-1 → IDLE.
- moeda and rejeitar are registered outputs; they are never asserted in the same cycle.

## Timing
- Reset values: moeda=00, rejeitar=0, busy=0, state IDLE, counters 0, synchronisers 0. Reset takes effect immediately, including mid-DEBOUNCE or mid-LOCKOUT; no pending emission survives.
- Edge E0 is the first rising edge at which a sensor is sampled high by the first sync flop.
- The FSM enters DEBOUNCE at edge E0+2.
- moeda/rejeitar assert at edge E0+2+DEBOUNCE_CYCLES and deassert on the next edge.
- busy rises at edge E0+2. It falls LOCKOUT_CYCLES cycles after WAIT_RELEASE completes.
- Minimum spacing between two accepted coins is 2·DEBOUNCE_CYCLES+LOCKOUT_CYCLES+2 cycles plus the time the coin is held on a sensor.
- A sensor high for fewer than DEBOUNCE_CYCLES synchronised cycles produces no output.

## Test plan
Use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
- sensor_a high 10 cycles, inhibit=0 → moeda=01 for exactly one cycle at E0+6; rejeitar=0; busy returns to 0 after release + 4 + 8 cycles.
- sensor_b high 3 cycles → no moeda, no rejeitar; FSM returns to IDLE, busy=0 within 2 cycles of the sensor dropping.
- sensor_a high 2 cycles, then sensor_a and sensor_b high together 10 cycles → single moeda=11 pulse; no 01 pulse.
- inhibit=1, sensor_b high 10 cycles → rejeitar one-cycle pulse at E0+6; moeda stays 00 throughout.
- Coin accepted (01); sensor_a pulsed again during LOCKOUT → ignored. A third coin after busy falls → accepted, second 01 pulse.
- reset asserted 2 cycles into DEBOUNCE → busy and outputs 0 immediately; after release, no pulse appears.
